btn_debounce_edge: RTL and testbench
====================================

Name: btn_debounce_edge

Overview:
Conditions the raw push-button before it reaches the double-tap monitor. It synchronises the asynchronous pin into the clk domain, normalises polarity, and debounces the level against a slow tick strobe from the clock-divider counter. It emits a clean level plus single-cycle press and release pulses for the downstream tap-counting logic.

Parameters:
CNT_W, 16, width of the debounce tick counter
DEBOUNCE_TICKS, 16'd20, consecutive tick_en strobes of a stable new level required to accept it; legal range 1..2^CNT_W-1; 0 behaves as 1
ACTIVE_LOW, 1, 1 = pin reads 0 when the button is pressed; 0 = pin reads 1 when pressed

Ports:
clk  input  1  system clock; sole clock of the block
rst  input  1  synchronous, active-high reset
tick_en  input  1  one-clk-wide strobe from the clock divider (nominally 1 kHz); all debounce timing counts these strobes
btn  input  1  raw asynchronous button pin
btn_level  output  1  debounced level; 1 = pressed
press_pulse  output  1  high for exactly one clk cycle when a press is accepted
release_pulse  output  1  high for exactly one clk cycle when a release is accepted
busy  output  1  high while a candidate level change is being qualified

Behaviour:
- One clock: clk. Reset: rst is synchronous and active-high. All flops update only on posedge clk.
- Reset values: btn_level=0, press_pulse=0, release_pulse=0, busy=0, FSM=RELEASED, counter=0, both synchroniser flops=0 (the released level after polarity normalisation).
- Input path: btn is XORed with ACTIVE_LOW to give pressed=1, then passed through 2 flops to give btn_s. btn_s lags btn by 2 clk cycles.
- FSM states: RELEASED, CONFIRM_PRESS, HELD, CONFIRM_RELEASE.
- RELEASED: btn_s=1 -> CONFIRM_PRESS, counter cleared to 0.
- CONFIRM_PRESS:
  - btn_s=0 -> RELEASED, counter cleared; no pulse. A bounce aborts qualification.
  - btn_s=1 and tick_en=1: if counter==DEBOUNCE_TICKS-1 -> HELD, else counter+1.
  - btn_s=1 and tick_en=0: hold.
- HELD: btn_s=0 -> CONFIRM_RELEASE, counter cleared.
- CONFIRM_RELEASE: mirror of CONFIRM_PRESS with the levels inverted. btn_s=1 aborts back to HELD. Qualification completes to RELEASED.
- Simultaneous btn_s mismatch and tick_en in a CONFIRM state: the abort wins and the tick is not counted.
- Outputs are registered:
  - btn_level=1 exactly in HELD and CONFIRM_RELEASE.
  - press_pulse=1 in the single cycle after the CONFIRM_PRESS->HELD transition edge, i.e. coincident with btn_level first reading 1.
  - release_pulse is the mirror for CONFIRM_RELEASE->RELEASED.
  - busy=1 in both CONFIRM states.
- press_pulse and release_pulse are never both high. Each is followed by at least DEBOUNCE_TICKS tick_en strobes before the opposite pulse can occur.
- Latency: a clean pin change is accepted on the clk edge of the DEBOUNCE_TICKS-th tick_en strobe counted after btn_s changes. btn_s itself changes 2 clk after btn.
- Counter never wraps: it is compared and cleared before reaching 2^CNT_W-1.
- Reset mid-qualification: the FSM returns to RELEASED and no pulse is emitted. If the button is still held, a fresh press is qualified from zero after reset deasserts.
- tick_en stuck low: the FSM stalls in its CONFIRM state with busy=1 and outputs unchanged.

Test Plan:
- Reset, ACTIVE_LOW=1, btn=1, DEBOUNCE_TICKS=20, tick_en every 50 clk -> all outputs 0 and no pulses for 5000 clk.
- Drive btn 1->0 and hold -> busy=1 three clk later. On the 20th tick_en edge FSM enters HELD. Next cycle btn_level=1 and press_pulse=1 for exactly 1 clk, busy=0.
- Bounce: btn toggles 0/1 every 120 clk for 1000 clk, then holds 0 -> no press_pulse during bouncing. Exactly one press_pulse 20 ticks after the final stable edge.
- Release from HELD: btn=1 held -> one release_pulse after 20 ticks and btn_level=0. A 5-tick glitch back to 0 while releasing aborts the release and emits no press_pulse.
- Assert rst for 1 clk at tick 10 of a press qualification with btn still 0 -> outputs 0 at once, then press_pulse 20 ticks after rst deasserts.
- DEBOUNCE_TICKS=1 and DEBOUNCE_TICKS=0 -> press accepted on the first tick_en after btn_s changes. tick_en coinciding with btn_s reverting is not counted.

Source files
------------

// File: rtl/btn_debounce_edge.sv
// btn_debounce_edge: synchronises, polarity-normalises and debounces a push-button against tick_en strobes
module btn_debounce_edge #(
    parameter int               CNT_W          = 16,
    parameter logic [CNT_W-1:0] DEBOUNCE_TICKS = 16'd20,
    parameter logic             ACTIVE_LOW     = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_en,
    input  logic btn,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic busy
);
    typedef enum logic [1:0] {RELEASED, CONFIRM_PRESS, HELD, CONFIRM_RELEASE} state_t;
    // a zero tick count qualifies on the first strobe, same as one
    localparam logic [CNT_W-1:0] LAST = (DEBOUNCE_TICKS == '0) ? '0 : DEBOUNCE_TICKS - 1'b1;
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       sync;
    logic             btn_s;
    assign btn_s = sync[1];
    // a level mismatch is checked before tick_en so a bounce always wins over a coincident strobe
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            RELEASED: begin
                state_n = btn_s ? CONFIRM_PRESS : RELEASED;
                cnt_n   = '0;
            end
            CONFIRM_PRESS: begin
                state_n = !btn_s ? RELEASED : (tick_en && cnt == LAST) ? HELD : CONFIRM_PRESS;
                cnt_n   = (!btn_s || (tick_en && cnt == LAST)) ? '0 : tick_en ? cnt + 1'b1 : cnt;
            end
            HELD: begin
                state_n = !btn_s ? CONFIRM_RELEASE : HELD;
                cnt_n   = '0;
            end
            CONFIRM_RELEASE: begin
                state_n = btn_s ? HELD : (tick_en && cnt == LAST) ? RELEASED : CONFIRM_RELEASE;
                cnt_n   = (btn_s || (tick_en && cnt == LAST)) ? '0 : tick_en ? cnt + 1'b1 : cnt;
            end
            default: begin
                state_n = RELEASED;
                cnt_n   = '0;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sync          <= '0;
            state         <= RELEASED;
            cnt           <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            busy          <= 1'b0;
        end else begin
            sync          <= {sync[0], btn ^ ACTIVE_LOW};
            state         <= state_n;
            cnt           <= cnt_n;
            btn_level     <= state_n == HELD || state_n == CONFIRM_RELEASE;
            press_pulse   <= state == CONFIRM_PRESS && state_n == HELD;
            release_pulse <= state == CONFIRM_RELEASE && state_n == RELEASED;
            busy          <= state_n == CONFIRM_PRESS || state_n == CONFIRM_RELEASE;
        end
    end
endmodule

// File: tb/tb_btn_debounce_edge.sv
// tb_btn_debounce_edge: directed stimulus with a pulse scoreboard over three parameterisations
module tb_btn_debounce_edge;
    localparam int PER = 50;
    typedef struct {int dut; logic rel; int cyc;} ev_t;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_en = 1'b0;
    logic [2:0] btn = 3'b101;
    logic [2:0] lvl, pp, rp, bsy;
    ev_t        exp_q[$];
    ev_t        mon_e;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    int         k, e, m0, t0, r_cyc;
    always #5 clk = ~clk;
    btn_debounce_edge #(.CNT_W(16), .DEBOUNCE_TICKS(16'd20), .ACTIVE_LOW(1'b1)) u_a (
        .clk(clk), .rst(rst), .tick_en(tick_en), .btn(btn[0]), .btn_level(lvl[0]),
        .press_pulse(pp[0]), .release_pulse(rp[0]), .busy(bsy[0]));
    btn_debounce_edge #(.CNT_W(16), .DEBOUNCE_TICKS(16'd1), .ACTIVE_LOW(1'b0)) u_b (
        .clk(clk), .rst(rst), .tick_en(tick_en), .btn(btn[1]), .btn_level(lvl[1]),
        .press_pulse(pp[1]), .release_pulse(rp[1]), .busy(bsy[1]));
    btn_debounce_edge #(.CNT_W(16), .DEBOUNCE_TICKS(16'd0), .ACTIVE_LOW(1'b1)) u_c (
        .clk(clk), .rst(rst), .tick_en(tick_en), .btn(btn[2]), .btn_level(lvl[2]),
        .press_pulse(pp[2]), .release_pulse(rp[2]), .busy(bsy[2]));
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
            tick_en = ((cyc + 1) % PER == 0);
        end
    endtask
    task automatic wait_mod(input int m);
        while (cyc % PER != m) step(1);
    endtask
    task automatic run_to(input int c);
        while (cyc < c) step(1);
    endtask
    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask
    task automatic expect_ev(input int d, input logic r, input int c);
        exp_q.push_back('{d, r, c});
    endtask
    function automatic int exp_edge(input int kk, input int n);
        int first;
        first = ((kk + 4 + PER - 1) / PER) * PER;
        return first + (n - 1) * PER;
    endfunction
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (pp[i] || rp[i]) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_pulse dut%0d press=%0b release=%0b at cycle %0d, none expected",
                             i, pp[i], rp[i], cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.dut != i || mon_e.rel != rp[i] || mon_e.cyc != cyc || pp[i] == rp[i]) begin
                        n_fail++;
                        $display("FAIL pulse dut%0d press=%0b release=%0b cycle %0d, expected dut%0d release=%0b cycle %0d",
                                 i, pp[i], rp[i], cyc, mon_e.dut, mon_e.rel, mon_e.cyc);
                    end
                end
            end
        end
    end
    initial begin
        step(3);
        chk("reset_outputs", int'({lvl, pp, rp, bsy}), 0);
        rst = 1'b0;
        step(5000);
        chk("idle_outputs", int'({lvl, pp, rp, bsy}), 0);
        // clean press on the 20-tick instance
        wait_mod(10);
        k = cyc;
        btn[0] = 1'b0;
        e = exp_edge(k, 20);
        expect_ev(0, 1'b0, e);
        step(2);
        chk("press_busy_early", int'(bsy[0]), 0);
        step(1);
        chk("press_busy", int'(bsy[0]), 1);
        run_to(e - 1);
        chk("press_pre_level", int'(lvl[0]), 0);
        chk("press_pre_busy", int'(bsy[0]), 1);
        step(1);
        chk("press_level", int'(lvl[0]), 1);
        chk("press_busy_done", int'(bsy[0]), 0);
        step(1);
        chk("press_level_hold", int'(lvl[0]), 1);
        // release aborted by a glitch after five ticks
        wait_mod(10);
        k = cyc;
        btn[0] = 1'b1;
        m0 = exp_edge(k, 1);
        run_to(m0 + 210);
        chk("rel_busy", int'(bsy[0]), 1);
        btn[0] = 1'b0;
        step(2);
        chk("glitch_busy", int'(bsy[0]), 1);
        step(2);
        chk("glitch_abort_busy", int'(bsy[0]), 0);
        chk("glitch_abort_level", int'(lvl[0]), 1);
        wait_mod(10);
        k = cyc;
        btn[0] = 1'b1;
        e = exp_edge(k, 20);
        expect_ev(0, 1'b1, e);
        run_to(e);
        chk("release_level", int'(lvl[0]), 0);
        chk("release_busy", int'(bsy[0]), 0);
        // bouncing press: only the final stable edge qualifies
        wait_mod(10);
        t0 = cyc;
        for (int i = 0; i < 9; i++) begin
            btn[0] = (i % 2 == 1);
            if (i < 8) step(120);
        end
        chk("bounce_level", int'(lvl[0]), 0);
        k = cyc;
        e = exp_edge(k, 20);
        expect_ev(0, 1'b0, e);
        run_to(e);
        chk("bounce_press_level", int'(lvl[0]), 1);
        // reset in the middle of a press qualification
        wait_mod(10);
        k = cyc;
        btn[0] = 1'b1;
        e = exp_edge(k, 20);
        expect_ev(0, 1'b1, e);
        run_to(e + 1);
        wait_mod(10);
        k = cyc;
        btn[0] = 1'b0;
        m0 = exp_edge(k, 1);
        run_to(m0 + 459);
        chk("rst_pre_busy", int'(bsy[0]), 1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        r_cyc = cyc;
        chk("rst_mid_outputs", int'({lvl[0], pp[0], rp[0], bsy[0]}), 0);
        e = exp_edge(r_cyc, 20);
        expect_ev(0, 1'b0, e);
        run_to(e);
        chk("rst_repress_level", int'(lvl[0]), 1);
        // one-tick and zero-tick instances
        wait_mod(10);
        k = cyc;
        btn[1] = 1'b1;
        btn[2] = 1'b0;
        e = exp_edge(k, 1);
        expect_ev(1, 1'b0, e);
        expect_ev(2, 1'b0, e);
        run_to(e);
        chk("short_press_level", int'(lvl[2:1]), 3);
        wait_mod(10);
        k = cyc;
        btn[1] = 1'b0;
        btn[2] = 1'b1;
        e = exp_edge(k, 1);
        expect_ev(1, 1'b1, e);
        expect_ev(2, 1'b1, e);
        run_to(e);
        chk("short_release_level", int'(lvl[2:1]), 0);
        // revert seen on the same edge as tick_en must abort, not accept
        wait_mod(44);
        btn[1] = 1'b1;
        btn[2] = 1'b0;
        step(3);
        chk("coincide_busy", int'(bsy[2:1]), 3);
        btn[1] = 1'b0;
        btn[2] = 1'b1;
        step(2);
        chk("coincide_busy_hold", int'(bsy[2:1]), 3);
        step(1);
        chk("coincide_abort", int'({lvl[2:1], bsy[2:1]}), 0);
        step(200);
        chk("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
